// File: rtl/face_detect_div_26s_16ns_10s_seq.sv
// Sequential restoring divider: signed 26-bit dividend by unsigned 16-bit
// divisor, one quotient bit per cycle, signed 10-bit saturated quotient.
//
// Handshake rules: an operand pair is taken on a rising edge where
// in_valid & in_ready & ce; a result is released on a rising edge where
// out_valid & out_ready & ce. in_ready is high only in IDLE, and out_valid
// is high only in DONE. Both are decoded from the state register alone.
module face_detect_div_26s_16ns_10s_seq #(
    parameter int unsigned ID         = 32'd1,
    parameter int unsigned NUM_STAGE  = 32'd28,
    parameter int unsigned din0_WIDTH = 32'd26,
    parameter int unsigned din1_WIDTH = 32'd16,
    parameter int unsigned dout_WIDTH = 32'd10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH:0]   rem,
    output logic                  sat,
    output logic                  dbz
);

    localparam int W0 = din0_WIDTH;
    localparam int W1 = din1_WIDTH;
    localparam int DW = dout_WIDTH;
    localparam int RW = din1_WIDTH + 1;
    localparam int CW = $clog2(din0_WIDTH);

    localparam logic [CW-1:0] CNT_INIT = CW'(W0 - 1);
    // Largest quotient magnitudes representable without clamping.
    localparam logic [W0-1:0] QMAX_POS = W0'((1 << (DW - 1)) - 1);
    localparam logic [W0-1:0] QMAX_NEG = W0'(1 << (DW - 1));
    localparam logic [DW-1:0] DOUT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] DOUT_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [RW-1:0]   prem;      // partial remainder
    logic [W0-1:0]   mag;       // dividend magnitude, becomes the quotient
    logic [W1-1:0]   dvs;       // latched divisor
    logic            neg;       // dividend sign
    logic            dbz_i;     // zero divisor seen at accept

    logic [W0-1:0]   din0_mag;
    logic [RW-1:0]   sh;
    logic [RW-1:0]   diff;
    logic            ge;
    logic            sat_hi;
    logic            sat_lo;
    logic [DW-1:0]   q_signed;
    logic [RW-1:0]   rem_signed;
    logic            unused_params;

    // ID and NUM_STAGE only matter to the HLS scheduler.
    assign unused_params = ^{ID, NUM_STAGE};

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Datapath for one restoring step and for the final sign/saturation fix-up.
    always_comb begin
        din0_mag   = din0[W0-1] ? (W0'(0) - din0) : din0;
        sh         = {prem[RW-2:0], mag[W0-1]};
        ge         = (sh >= {1'b0, dvs});
        diff       = sh - {1'b0, dvs};
        sat_hi     = !neg && (mag > QMAX_POS);
        sat_lo     = neg && (mag > QMAX_NEG);
        q_signed   = neg ? (DW'(0) - mag[DW-1:0]) : mag[DW-1:0];
        rem_signed = neg ? (RW'(0) - prem) : prem;
    end

    // Control FSM plus datapath and output registers, all gated by ce.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            prem  <= '0;
            mag   <= '0;
            dvs   <= '0;
            neg   <= 1'b0;
            dbz_i <= 1'b0;
            dout  <= '0;
            rem   <= '0;
            sat   <= 1'b0;
            dbz   <= 1'b0;
        end else if (ce) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag   <= din0_mag;
                        dvs   <= din1;
                        neg   <= din0[W0-1];
                        prem  <= '0;
                        cnt   <= CNT_INIT;
                        dbz_i <= (din1 == '0);
                        state <= (din1 == '0) ? FIN : CALC;
                    end
                end
                CALC: begin
                    prem <= ge ? diff : sh;
                    mag  <= {mag[W0-2:0], ge};
                    if (cnt == '0) begin
                        state <= FIN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FIN: begin
                    if (dbz_i) begin
                        dout <= neg ? DOUT_MIN : DOUT_MAX;
                        rem  <= '0;
                        sat  <= 1'b0;
                        dbz  <= 1'b1;
                    end else begin
                        dout <= sat_hi ? DOUT_MAX : (sat_lo ? DOUT_MIN : q_signed);
                        rem  <= rem_signed;
                        sat  <= sat_hi | sat_lo;
                        dbz  <= 1'b0;
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_face_detect_div_26s_16ns_10s_seq.sv
// Directed bench for the sequential 26s/16ns divider.
module tb_face_detect_div_26s_16ns_10s_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        in_valid;
    logic        in_ready;
    logic [25:0] din0;
    logic [15:0] din1;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  dout;
    logic [16:0] rem;
    logic        sat;
    logic        dbz;

    int vectors = 0;
    int errors  = 0;
    int lat;

    face_detect_div_26s_16ns_10s_seq dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din0      (din0),
        .din1      (din1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .rem       (rem),
        .sat       (sat),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present operands for one edge; returns in cycle 1 after the accept.
    task automatic start(input int a, input int b);
        din0     = a[25:0];
        din1     = b[15:0];
        in_valid = 1'b1;
        check("in_ready_before_accept", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count cycles until out_valid, bounded.
    task automatic wait_valid(input int l0, output int l);
        l = l0;
        while (!out_valid && l < 200) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("in_ready_after_handshake", int'(in_ready), 1);
        check("out_valid_after_handshake", int'(out_valid), 0);
    endtask

    task automatic check_result(input string tag, input int q, input int r,
                                input int s, input int z);
        check({tag, "_out_valid"}, int'(out_valid), 1);
        check({tag, "_dout"}, $signed(dout), q);
        check({tag, "_rem"}, $signed(rem), r);
        check({tag, "_sat"}, int'(sat), s);
        check({tag, "_dbz"}, int'(dbz), z);
    endtask

    initial begin
        reset     = 1'b1;
        ce        = 1'b1;
        in_valid  = 1'b0;
        din0      = '0;
        din1      = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_dout", $signed(dout), 0);
        check("rst_rem", $signed(rem), 0);
        check("rst_sat", int'(sat), 0);
        check("rst_dbz", int'(dbz), 0);
        reset = 1'b0;

        // 1000 / 7 = 142 r 6, result in cycle 28
        start(1000, 7);
        wait_valid(1, lat);
        check("lat_1000_7", lat, 28);
        check_result("p1000_7", 142, 6, 0, 0);
        finish_op();

        // -1000 / 7 = -142 r -6
        start(-1000, 7);
        wait_valid(1, lat);
        check_result("n1000_7", -142, -6, 0, 0);
        finish_op();

        // multiplier round trip: -12000000 / 40000 = -300
        start(-12000000, 40000);
        wait_valid(1, lat);
        check_result("roundtrip", -300, 0, 0, 0);
        finish_op();

        // positive saturation
        start(33554431, 1);
        wait_valid(1, lat);
        check_result("sat_pos", 511, 0, 1, 0);
        finish_op();

        // negative saturation: 33554432 / 3 = 11184810 r 2
        start(-33554432, 3);
        wait_valid(1, lat);
        check_result("sat_neg", -512, -2, 1, 0);
        finish_op();

        // divide by zero, result in cycle 2
        start(5, 0);
        wait_valid(1, lat);
        check("lat_dbz", lat, 2);
        check_result("dbz_pos", 511, 0, 0, 1);
        finish_op();

        start(-5, 0);
        wait_valid(1, lat);
        check_result("dbz_neg", -512, 0, 0, 1);
        finish_op();

        // back-pressure: 77 / 5 = 15 r 2 held for 10 cycles, new operands ignored
        start(77, 5);
        wait_valid(1, lat);
        din0     = 26'd999;
        din1     = 16'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_dout", $signed(dout), 15);
            check("hold_rem", $signed(rem), 2);
            check("hold_in_ready", int'(in_ready), 0);
            check("hold_out_valid", int'(out_valid), 1);
        end
        in_valid = 1'b0;
        check_result("hold_final", 15, 2, 0, 0);
        finish_op();

        // ce low for 5 cycles in CALC: latency 28 + 5
        start(1000, 7);
        lat = 1;
        repeat (5) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ce = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ce = 1'b1;
        wait_valid(lat, lat);
        check("lat_ce_stall", lat, 33);
        check_result("ce_stall", 142, 6, 0, 0);
        finish_op();

        // reset in cycle 10 of CALC aborts the operation
        start(1000, 7);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_dout", $signed(dout), 0);
        check("abort_rem", $signed(rem), 0);
        check("abort_sat", int'(sat), 0);
        check("abort_dbz", int'(dbz), 0);
        start(1000, 7);
        wait_valid(1, lat);
        check("lat_after_abort", lat, 28);
        check_result("after_abort", 142, 6, 0, 0);
        finish_op();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/face_detect_div_26s_16ns_10s_seq.md
# face_detect_div_26s_16ns_10s_seq

Sequential signed-by-unsigned divider for the face-detection accelerator. It recovers a 10-bit signed coefficient from a 26-bit signed fixed-point product by dividing it by a 16-bit unsigned scale factor. This is the inverse of the 16ns×10s→26 pipelined multiplier stage. It is used on the normalisation path, where HLS-generated logic must undo a scale-multiply. Division is restoring, one quotient bit per cycle, with valid/ready handshakes on both sides and a global clock-enable consistent with the other arithmetic cores.

## Interface
Parameters (only the defaults are supported; the other values exist for HLS wrapper compatibility):
- ID, 32'd1: instance tag; no functional effect
- NUM_STAGE, 32'd28: nominal latency reported to the scheduler
- din0_WIDTH, 32'd26: dividend width
- din1_WIDTH, 32'd16: divisor width
- dout_WIDTH, 32'd10: quotient width

Ports (one clock, `clk`; reset `reset` is synchronous, active-high):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- ce  in  1  clock enable; when low, all state and outputs hold
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands; equals (state==IDLE)
- din0  in  26  dividend, signed two's complement
- din1  in  16  divisor, unsigned
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- dout  out  10  quotient, signed, saturated
- rem  out  17  remainder, signed
- sat  out  1  quotient was saturated
- dbz  out  1  divisor was zero

## Operation
- States: IDLE, CALC, FIN, DONE. Every transition and register update is qualified by ce=1.
- IDLE → CALC on accept (in_valid & in_ready & ce) when din1≠0.
  - On accept, latch |din0| as a 26-bit unsigned magnitude (−2^25 maps to 2^25), latch din1, latch sign(din0).
  - Clear the 17-bit partial remainder; set the step counter to 25.
- IDLE → FIN on accept when din1==0. This skips CALC and sets the internal dbz flag.
- CALC, one step per cycle:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - If partial remainder ≥ divisor, subtract the divisor and shift in quotient bit 1; otherwise shift in 0.
  - After the step with counter==0, go to FIN; otherwise decrement the counter.
- FIN: compute the registered outputs, then go to DONE.
  - Quotient sign = sign(din0). Truncation is toward zero (C semantics).
  - Remainder = ±partial remainder, with the sign of the dividend (zero remainder is 0).
  - Saturation: a signed quotient >511 gives 511; a signed quotient <−512 gives −512. sat=1 when clamping occurs. The remainder is still the true remainder.
  - dbz case: dout = 511 if din0≥0, else −512; rem=0; dbz=1; sat=0.
- DONE: out_valid=1; dout/rem/sat/dbz are stable. DONE → IDLE on out_ready & ce.
- in_valid is ignored outside IDLE. No operand queuing.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, dout=0, rem=0, sat=0, dbz=0, counter=0.
- Reset mid-operation (any state) aborts the operation at the next edge. No out_valid is produced for the aborted operation.
- Latency, from the accept edge (cycle 0):
  - CALC occupies cycles 1–26, FIN is cycle 27, out_valid rises in cycle 28.
  - The dbz path: FIN is cycle 1, out_valid rises in cycle 2.
- ce low stretches latency one-for-one. The counter, datapath, and outputs freeze. out_valid stays asserted while in DONE.
- Throughput: one result per 29 cycles at best.
  - in_ready rises the cycle after the out_valid & out_ready & ce handshake.
  - The next accept can occur in that cycle.
- Outputs are registered. No combinational path runs from din0/din1/in_valid to any output. in_ready depends only on state.
- out_ready held low keeps DONE indefinitely; outputs do not change.

## Test plan
- Basic divides:
  - din0=1000, din1=7 → dout=142, rem=6, sat=0, dbz=0, out_valid exactly 28 cycles after accept.
  - din0=−1000, din1=7 → dout=−142, rem=−6.
- Round trip with the multiplier: din0=−12000000 (40000×−300), din1=40000 → dout=−300, rem=0, sat=0.
- Saturation:
  - din0=2^25−1, din1=1 → dout=511, sat=1, rem=0.
  - din0=−2^25, din1=3 → dout=−512, sat=1, rem=−2.
- Divide by zero:
  - din0=5, din1=0 → dout=511, dbz=1, rem=0, out_valid 2 cycles after accept.
  - din0=−5, din1=0 → dout=−512, dbz=1.
- Handshake and ce:
  - Hold out_ready=0 for 10 cycles in DONE: outputs stable, in_ready=0, new in_valid ignored.
  - Toggle ce low for 5 cycles mid-CALC: out_valid is delayed by exactly 5 cycles, result unchanged.
- Reset mid-CALC (cycle 10): next cycle in_ready=1, out_valid=0, all outputs 0. A following 1000/7 still gives 142 r 6.
